// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the program loader/processor side and the instruction sequencer.
// The bench drives the master side; the sequencer is the slave.
interface instr_sequencer_if #(
    parameter int AW = 4
) ();
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [15:0]   LoadData;
    logic          Start;
    logic [AW:0]   Len;
    logic          Done;
    logic [15:0]   DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [AW-1:0] PC;

    modport master (
        output LoadEn, LoadAddr, LoadData, Start, Len, Done,
        input  DIN, Run, Busy, Halted, Error, PC
    );

    modport slave (
        input  LoadEn, LoadAddr, LoadData, Start, Len, Done,
        output DIN, Run, Busy, Halted, Error, PC
    );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a stored program word by word to a processor: one Run pulse per word,
// then waits for Done, with a timeout that parks the sequencer in an error state.
module instr_sequencer #(
    parameter int AW  = 4,
    parameter int TMO = 15
) (
    input logic               Clock,
    input logic               Resetn,
    instr_sequencer_if.slave  bus
);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HALT, ERR} state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued_q;
    logic [CW-1:0] wait_cnt_q;
    logic          run_q;
    logic          busy_q;
    logic          halted_q;
    logic          error_q;
    logic [15:0]   mem_q [2**AW];

    logic [AW-1:0] pc_d;
    logic [AW:0]   issued_d;

    assign pc_d     = pc_q + AW'(1);
    assign issued_d = issued_q + (AW + 1)'(1);

    // NOTE: the program buffer deliberately has no reset; its contents must survive Resetn.
    always_ff @(posedge Clock) begin
        if (bus.LoadEn) begin
            mem_q[bus.LoadAddr] <= bus.LoadData;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            wait_cnt_q <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        len_q    <= bus.Len;
                        pc_q     <= '0;
                        issued_q <= '0;
                        error_q  <= 1'b0;
                        if (bus.Len == '0) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            halted_q <= 1'b0;
                            run_q    <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= CW'(1);
                end
                WAIT: begin
                    // Done wins over the timeout on the last permitted wait cycle.
                    if (bus.Done) begin
                        pc_q     <= pc_d;
                        issued_q <= issued_d;
                        if (issued_d == len_q) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                            run_q   <= 1'b1;
                        end
                    end else if (wait_cnt_q == CW'(TMO)) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                HALT, ERR: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // DIN reads the buffer live so a load to the presented index shows up one cycle later.
    assign bus.DIN    = busy_q ? mem_q[pc_q] : 16'h0000;
    assign bus.Run    = run_q;
    assign bus.Busy   = busy_q;
    assign bus.Halted = halted_q;
    assign bus.Error  = error_q;
    assign bus.PC     = pc_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a per-program timeline model predicts every output on every
// cycle, with directed scenarios, literal spot checks and randomized programs.
module tb_instr_sequencer;
    localparam int AW    = 4;
    localparam int TMO   = 15;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          run;
        logic          busy;
        logic          halted;
        logic          error;
        logic [AW-1:0] pc;
        logic [15:0]   din;
    } exp_t;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    instr_sequencer_if #(.AW(AW)) bus ();

    instr_sequencer #(.AW(AW), .TMO(TMO)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          want;
    logic          exp_valid = 1'b0;
    logic [15:0]   m_buf [DEPTH];
    logic [AW-1:0] m_pc     = '0;
    logic          m_halted = 1'b0;
    logic          m_error  = 1'b0;
    int            delays[$];
    logic [15:0]   run_dins[$];
    int            busy_cycles = 0;
    bit            wr_noise    = 1'b0;
    bit            ctl_noise   = 1'b0;
    int            abort_word  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Single compare process: outputs sampled on the falling edge, away from the active edge.
    always @(negedge Clock) begin
        if (exp_valid) begin
            check("Run",    {31'd0, bus.Run},    {31'd0, want.run});
            check("Busy",   {31'd0, bus.Busy},   {31'd0, want.busy});
            check("Halted", {31'd0, bus.Halted}, {31'd0, want.halted});
            check("Error",  {31'd0, bus.Error},  {31'd0, want.error});
            check("PC",     32'(bus.PC),         32'(want.pc));
            check("DIN",    32'(bus.DIN),        32'(want.din));
            if (bus.Run)  run_dins.push_back(bus.DIN);
            if (bus.Busy) busy_cycles++;
        end
    end

    function automatic exp_t mk(input logic r, input logic b, input logic h, input logic e,
                                input logic [AW-1:0] p, input logic [15:0] d);
        exp_t x;
        x.run = r; x.busy = b; x.halted = h; x.error = e; x.pc = p; x.din = d;
        return x;
    endfunction

    function automatic exp_t idle_exp();
        return mk(1'b0, 1'b0, m_halted, m_error, m_pc, 16'h0000);
    endfunction

    function automatic logic rnd_bit();
        return ctl_noise && ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [AW:0] rnd_len();
        return ctl_noise ? (AW + 1)'($urandom) : bus.Len;
    endfunction

    // One clock cycle: e is what the outputs must show during it; inputs take effect at the next edge.
    task automatic cyc(input exp_t e, input logic st, input logic dn, input logic [AW:0] ln,
                       input logic we, input logic [AW-1:0] wa, input logic [15:0] wd);
        @(posedge Clock);
        #2;
        want      = e;
        exp_valid = 1'b1;
        bus.Start    = st;
        bus.Done     = dn;
        bus.Len      = ln;
        bus.LoadEn   = we;
        bus.LoadAddr = wa;
        bus.LoadData = wd;
        if (we) m_buf[wa] = wd;
    endtask

    task automatic step(input exp_t e, input logic st, input logic dn, input logic [AW:0] ln);
        logic we;
        we = wr_noise && ($urandom_range(0, 3) == 0);
        cyc(e, st, dn, ln, we, AW'($urandom), 16'($urandom));
    endtask

    task automatic load(input int a, input logic [15:0] d);
        cyc(idle_exp(), 1'b0, 1'b0, '0, 1'b1, AW'(a), d);
    endtask

    task automatic reset_mid_wait();
        @(posedge Clock);
        #2;
        exp_valid  = 1'b0;
        bus.Start  = 1'b0;
        bus.Done   = 1'b0;
        bus.LoadEn = 1'b0;
        check("busy_before_reset", {31'd0, bus.Busy}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("rst_Run",    {31'd0, bus.Run},    32'd0);
        check("rst_Busy",   {31'd0, bus.Busy},   32'd0);
        check("rst_Halted", {31'd0, bus.Halted}, 32'd0);
        check("rst_Error",  {31'd0, bus.Error},  32'd0);
        check("rst_PC",     32'(bus.PC),         32'd0);
        check("rst_DIN",    32'(bus.DIN),        32'd0);
        m_pc = '0; m_halted = 1'b0; m_error = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    // Timeline of one program: per word one ISSUE cycle, then WAIT cycles until the planned Done
    // (delays[k] = WAIT cycle in which Done is raised; beyond TMO means never), then HALT or ERR.
    task automatic run_prog(input int len);
        logic [AW-1:0] a;
        int            d;
        bit            failed;
        failed = 1'b0;
        step(idle_exp(), 1'b1, rnd_bit(), (AW + 1)'(len));
        m_pc = '0; m_halted = 1'b0; m_error = 1'b0;
        for (int k = 0; k < len && !failed; k++) begin
            a = AW'(k % DEPTH);
            step(mk(1'b1, 1'b1, 1'b0, 1'b0, a, m_buf[a]), rnd_bit(), rnd_bit(), rnd_len());
            d = (delays.size() > k) ? delays[k] : 1;
            for (int w = 1; w <= TMO; w++) begin
                if (k == abort_word && w == 2) begin
                    reset_mid_wait();
                    return;
                end
                step(mk(1'b0, 1'b1, 1'b0, 1'b0, a, m_buf[a]), rnd_bit(), (w == d), rnd_len());
                if (w == d) break;
            end
            if (d > TMO) begin
                step(mk(1'b0, 1'b0, 1'b0, 1'b1, a, 16'h0000), rnd_bit(), rnd_bit(), rnd_len());
                m_error = 1'b1;
                failed  = 1'b1;
            end else begin
                m_pc = AW'((k + 1) % DEPTH);
            end
        end
        if (!failed) begin
            step(mk(1'b0, 1'b0, 1'b1, 1'b0, m_pc, 16'h0000), rnd_bit(), rnd_bit(), rnd_len());
            m_halted = 1'b1;
        end
        step(idle_exp(), 1'b0, rnd_bit(), rnd_len());
    endtask

    task automatic clear_mon();
        run_dins.delete();
        busy_cycles = 0;
    endtask

    initial begin
        bus.LoadEn = 1'b0; bus.LoadAddr = '0; bus.LoadData = '0;
        bus.Start  = 1'b0; bus.Len = '0;      bus.Done = 1'b0;

        #13;
        check("reset_Run",    {31'd0, bus.Run},    32'd0);
        check("reset_Busy",   {31'd0, bus.Busy},   32'd0);
        check("reset_Halted", {31'd0, bus.Halted}, 32'd0);
        check("reset_Error",  {31'd0, bus.Error},  32'd0);
        check("reset_PC",     32'(bus.PC),         32'd0);
        check("reset_DIN",    32'(bus.DIN),        32'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        load(0, 16'h1005);
        load(1, 16'h2203);
        load(2, 16'h4401);
        for (int i = 3; i < DEPTH; i++) load(i, 16'($urandom));

        // Three words, Done one cycle after each Run.
        clear_mon();
        delays = '{1, 1, 1};
        run_prog(3);
        check("t1_run_count", run_dins.size(), 32'd3);
        if (run_dins.size() == 3) begin
            check("t1_din0", 32'(run_dins[0]), 32'h1005);
            check("t1_din1", 32'(run_dins[1]), 32'h2203);
            check("t1_din2", 32'(run_dins[2]), 32'h4401);
        end
        check("t1_busy_cycles", busy_cycles, 32'd6);
        check("t1_halted", {31'd0, bus.Halted}, 32'd1);
        check("t1_pc", 32'(bus.PC), 32'd3);

        // Slow processor: Done three cycles into each wait.
        clear_mon();
        delays = '{3, 3};
        run_prog(2);
        check("t2_run_count", run_dins.size(), 32'd2);
        check("t2_busy_cycles", busy_cycles, 32'd8);

        // Done never arrives: timeout after TMO wait cycles.
        clear_mon();
        delays = '{TMO + 1};
        run_prog(1);
        check("t3_busy_cycles", busy_cycles, 32'(1 + TMO));
        check("t3_error", {31'd0, bus.Error}, 32'd1);
        check("t3_halted", {31'd0, bus.Halted}, 32'd0);
        check("t3_pc", 32'(bus.PC), 32'd0);
        check("t3_idle", {31'd0, bus.Busy}, 32'd0);

        // Empty program halts without any fetch.
        clear_mon();
        run_prog(0);
        check("t4_run_count", run_dins.size(), 32'd0);
        check("t4_halted", {31'd0, bus.Halted}, 32'd1);
        check("t4_error_cleared", {31'd0, bus.Error}, 32'd0);

        // Done while idle must be ignored; stray Start/Done while busy too.
        for (int i = 0; i < 3; i++) step(idle_exp(), 1'b0, 1'b1, '0);
        ctl_noise = 1'b1;
        delays = '{2, 2};
        run_prog(2);
        ctl_noise = 1'b0;
        check("t5_halted", {31'd0, bus.Halted}, 32'd1);
        check("t5_pc", 32'(bus.PC), 32'd2);

        // Done on the very last permitted wait cycle completes the word.
        delays = '{TMO};
        run_prog(1);
        check("t6_no_error", {31'd0, bus.Error}, 32'd0);

        // Program longer than the buffer wraps PC.
        delays = {};
        run_prog(DEPTH + 2);
        check("t7_pc_wrap", 32'(bus.PC), 32'd2);

        // Reset in the wait of word 2, then the buffer must still hold word 0.
        abort_word = 1;
        delays = '{1, 4, 1};
        run_prog(3);
        abort_word = -1;
        clear_mon();
        delays = '{1};
        run_prog(1);
        check("t8_run_count", run_dins.size(), 32'd1);
        if (run_dins.size() == 1) check("t8_din0", 32'(run_dins[0]), 32'h1005);

        // Randomized programs with live buffer writes and stray control.
        wr_noise  = 1'b1;
        ctl_noise = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(0, DEPTH + 4);
            delays = {};
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r < 14)       delays.push_back($urandom_range(1, 4));
                else if (r < 18)  delays.push_back($urandom_range(5, TMO));
                else if (r == 18) delays.push_back(TMO);
                else              delays.push_back(TMO + 1);
            end
            run_prog(len);
        end
        wr_noise  = 1'b0;
        ctl_noise = 1'b0;
        step(idle_exp(), 1'b0, 1'b0, '0);
        exp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
